mode_select: RTL
================

# mode_select

Upstream control stage for the pulse generator. Takes one raw, bouncing, active-low push button and produces the 2-bit `mode` that selects the generator's output frequency. Each short press advances the mode 0→1→2→3→0. A long press forces mode 0. The block runs on the same clock as the pulse generator, and `mode` is glitch-free, so it can drive the generator directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles the synchronized button must hold a new level before it is accepted (10 ms at 50 MHz).
- `LONG_PRESS_CYCLES`, default 100000000: debounced hold time, in cycles, that counts as a long press (2 s at 50 MHz). Must be greater than 0.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `btn_n`, input, 1: raw button, active-low, asynchronous to `clk`, may bounce.
- `mode`, output, 2: current mode; drives the pulse generator's `mode` input.
- `mode_changed`, output, 1: one-cycle strobe in the cycle `mode` takes a new value.
- `btn_pressed`, output, 1: debounced button level; 1 = pressed.

## Operation
- Synchronizer: two flip-flops on `btn_n`, then inversion, give `s` (1 = pressed).
- Debouncer:
  - The counter clears in any cycle where `s == btn_pressed`.
  - Otherwise it increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `s != btn_pressed`, then `btn_pressed <= s` and the counter clears.
- FSM states are IDLE, PRESSED and LONG_HELD. The hold counter runs only in PRESSED.
  - IDLE, rising edge of `btn_pressed`: go to PRESSED and clear the hold counter.
  - PRESSED, falling edge of `btn_pressed`: `mode <= mode+1` (2-bit wrap, 3→0), pulse `mode_changed`, go to IDLE.
  - PRESSED, hold counter reaches `LONG_PRESS_CYCLES-1`: go to LONG_HELD and `mode <= 0`. `mode_changed` pulses only if `mode` was not already 0.
  - LONG_HELD, falling edge of `btn_pressed`: go to IDLE with no mode change.
- The hold counter saturates and never wraps.
- Counter widths are `$clog2` of the respective parameter, plus 1.

## Timing
- Reset values: `mode`=0, `mode_changed`=0, `btn_pressed`=0, synchronizer flops=1 (released), both counters=0, state=IDLE.
- Raw edge to `btn_pressed`: 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles.
- Short press: `mode` and `mode_changed` update 1 cycle after `btn_pressed` falls.
- Long press: `mode` becomes 0 exactly `LONG_PRESS_CYCLES` cycles after `btn_pressed` rises.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no change on any output.
- Reset mid-press: all state returns to reset values. A button still held is debounced again as a fresh press.
- `mode` changes only on `clk` edges and is never X after reset.

## Configuration
- `MODE_SELECT_LONGPRESS_EN` defined: long-press behaviour as above; LONG_HELD and the hold counter exist.
- `MODE_SELECT_LONGPRESS_EN` undefined:
  - No hold counter and no LONG_HELD state.
  - `LONG_PRESS_CYCLES` is ignored.
  - Every release from PRESSED increments `mode`, however long the button was held.

## Structure
- Shared package `mode_select_pkg` holds:
  - the state enum (IDLE, PRESSED, LONG_HELD);
  - `MODE_W` = 2;
  - `MODE_RESET` = 2'd0.
- Sub-module `btn_debounce` contains the synchronizer and debouncer, with output `btn_pressed`. It is reused for any other panel button.
- The top level holds the FSM, the hold counter and the `mode` register.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, macro defined unless noted.
- Reset, then idle with `btn_n`=1 for 50 cycles → `mode`=0, `mode_changed` never 1, `btn_pressed`=0.
- Clean press of 10 cycles, then release → `btn_pressed` rises 6 cycles after the press. `mode` goes 0→1 one cycle after `btn_pressed` falls, with a single `mode_changed` pulse.
- Four short presses → `mode` sequence 1,2,3,0, and exactly four `mode_changed` pulses.
- `btn_n` toggles every 2 cycles for 30 cycles, then settles at 1 → `btn_pressed` stays 0 and `mode` is unchanged.
- `mode`=2, hold for 40 cycles → `mode`=0 at 20 cycles after `btn_pressed` rises, with one pulse; the release causes no further change. With the macro undefined, the same press gives `mode`=3 on release.
- `rst_n` pulled low mid-press at `mode`=3, button kept held → after reset `mode`=0. Release then gives `mode`=1.

Source files
------------

// File: rtl/mode_select_pkg.sv
// mode_select_pkg: shared state encoding and mode constants for the mode selector
package mode_select_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_RESET = 2'd0;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, LONG_HELD = 2'd2} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus counter debouncer for an active-low panel button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = ~sync[1];
  // bring the raw button into the clock domain, idling at released
  always_ff @(posedge clk)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], btn_n};
  // accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      btn_pressed <= 1'b0;
    end else if (s == btn_pressed) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      btn_pressed <= s;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/mode_select.sv
// mode_select: short press steps mode 0-3, long press (MODE_SELECT_LONGPRESS_EN) forces mode 0
module mode_select
  import mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic [MODE_W-1:0] mode,
  output logic mode_changed,
  output logic btn_pressed
);
  state_t state;
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be greater than 0");
  end
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .btn_pressed(btn_pressed)
  );
`ifdef MODE_SELECT_LONGPRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((LONG_PRESS_CYCLES > 1) ? LONG_PRESS_CYCLES - 2 : 0);
  logic [HW-1:0] hold;
  logic long_now;
  // the press is first seen one cycle after btn_pressed rises, so matching
  // LONG_PRESS_CYCLES-2 here lands the mode reset exactly LONG_PRESS_CYCLES after the rise
  assign long_now = btn_pressed && ((state == IDLE && LONG_PRESS_CYCLES == 1) ||
                                    (state == PRESSED && hold == HOLD_LAST));
  // saturating hold timer, cleared on press and advancing only while PRESSED
  always_ff @(posedge clk)
    if (!rst_n) hold <= '0;
    else if (state == IDLE && btn_pressed) hold <= '0;
    else if (state == PRESSED && hold != '1) hold <= hold + 1'b1;
`endif
  // press/release FSM owning the mode register and its change strobe
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      mode <= MODE_RESET;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
`ifdef MODE_SELECT_LONGPRESS_EN
      if (long_now) begin
        state <= LONG_HELD;
        mode <= MODE_RESET;
        mode_changed <= mode != MODE_RESET;
      end else
`endif
      if (state == IDLE && btn_pressed) state <= PRESSED;
      else if (state != IDLE && !btn_pressed) begin
        state <= IDLE;
        if (state == PRESSED) begin
          mode <= mode + 1'b1;
          mode_changed <= 1'b1;
        end
      end
    end
endmodule
